dpll_control: RTL and testbench
===============================

# dpll_control

Top-level search sequencer for the SAT solver. It drives the decider's read/write port to pick branching literals and hands each assignment to the BCP unit. It keeps the decision stack (trail of decisions), and on a conflict performs chronological backtracking: undo, flip, and rewind the decider. It sits between the decider, the BCP/propagation unit and the variable assignment table, and reports SAT/UNSAT.

## Interface
- NUM_VARS, 512, number of decider entries / variables.
- VAR_BITS, 9, width of variable and decider indices (clog2(NUM_VARS)).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a solve. Ignored while busy=1.
- dec_read  out  1  decider read; decider registers the entry at its pointer, then post-increments the pointer.
- dec_write  out  1  decider pointer load from dec_back_idx.
- dec_back_idx  out  VAR_BITS  pointer value for dec_write.
- dec_idx_in  in  VAR_BITS  decider dec_idx_out; valid the cycle after dec_read.
- dec_var_in  in  VAR_BITS  decider var_idx_out.
- dec_val_in  in  1  decider val_out.
- var_assigned  in  1  combinational lookup of dec_var_in in the assignment table.
- all_assigned  in  1  assignment table reports every variable assigned.
- prop_start  out  1  one-cycle pulse; BCP assigns prop_var=prop_val at prop_level, then propagates.
- prop_var  out  VAR_BITS; prop_val  out  1; prop_level  out  VAR_BITS.
- prop_done  in  1  one-cycle pulse, BCP finished.
- prop_conflict  in  1  qualifies prop_done.
- undo_req  out  1  level-held request to clear all assignments with level >= undo_level.
- undo_level  out  VAR_BITS; undo_ack  in  1  one-cycle completion pulse.
- busy, sat, unsat, error  out  1 each.

## Operation
- Decision stack: NUM_VARS entries of {dec_idx, var, val, flipped}. depth = current decision level (0..NUM_VARS).
- States: IDLE, REWIND, FETCH, CHECK, PROP_WAIT, BT_POP, BT_UNDO, BT_FLIP, DONE_SAT, DONE_UNSAT, ERR.
- IDLE: start -> REWIND. start also clears sat/unsat/error and sets depth=0.
- REWIND: dec_write=1, dec_back_idx=0 -> FETCH.
- FETCH: dec_read=1 for exactly one cycle -> CHECK.
- CHECK: samples the dec_* inputs.
  - If var_assigned=0: push {dec_idx_in, dec_var_in, dec_val_in, 0} and increment depth. Pulse prop_start with prop_var=dec_var_in, prop_val=dec_val_in, prop_level=new depth. Go to PROP_WAIT.
  - If var_assigned=1 and dec_idx_in != NUM_VARS-1: go to FETCH (skip).
  - If var_assigned=1 and dec_idx_in == NUM_VARS-1: go to DONE_SAT if all_assigned=1, else ERR.
- PROP_WAIT: on prop_done:
  - prop_conflict=1 -> BT_POP. Conflict wins over all_assigned.
  - else all_assigned=1 -> DONE_SAT.
  - else -> FETCH.
- BT_POP, evaluated each cycle:
  - depth==0 -> DONE_UNSAT.
  - top.flipped=1 -> depth-1, stay in BT_POP.
  - else -> BT_UNDO.
- BT_UNDO: undo_req=1, undo_level=depth, held until undo_ack. On ack, write top.val=~top.val and top.flipped=1, then go to BT_FLIP.
- BT_FLIP, one cycle, with both outputs asserted in that same cycle, then go to PROP_WAIT:
  - dec_write=1, dec_back_idx=top.dec_idx+1 (mod 2^VAR_BITS).
  - prop_start pulse with top.var, top.val, prop_level=depth.
- DONE_SAT / DONE_UNSAT / ERR: the respective flag is held high; busy=0. A new start restarts from REWIND.
- dec_read, dec_write, prop_start and undo_req are mutually exclusive, except dec_write with prop_start in BT_FLIP.

## Timing
- Reset values:
  - All outputs 0.
  - state=IDLE, depth=0.
  - Stack contents don't-care; never read below depth.
- busy=1 in every state except IDLE/DONE_*/ERR. busy rises the cycle after start.
- Fresh decision latency: FETCH -> CHECK -> prop_start = 2 cycles after entering FETCH. Each skipped assigned variable adds 2 cycles.
- prop_done/undo_ack are accepted only in PROP_WAIT/BT_UNDO. Stray pulses elsewhere are ignored.
- Registered outputs; no combinational path from inputs to dec_read/dec_write/prop_start/undo_req.
- Reset mid-operation: immediate return to IDLE, flags cleared, depth=0. No undo is issued; the assignment table is reset by the same reset.

## Test plan
- Reset then idle: all outputs 0; start while busy=1 is ignored; a second start after DONE_SAT restarts with dec_write, dec_back_idx=0.
- No conflicts, BCP model assigns only the decided var, NUM_VARS=4, config vars 0..3:
  - 4 pushes with prop_level 1,2,3,4.
  - all_assigned after the 4th prop_done -> sat=1, busy=0, depth=4.
- Skip: var_assigned=1 for decider entries 1 and 2 -> dec_read pulses 4 times for 2 pushes; pushed vars 0 and 3.
- Single conflict at level 2 (var 5, val 1, dec_idx 7):
  - undo_level=2, held until undo_ack.
  - Then dec_write with dec_back_idx=8, and prop_start with var 5, val 0, level 2, in the same cycle.
- Flipped level conflicts again:
  - BT_POP pops to level 1, undo_level=1, and level-1 val is inverted.
  - Conflict with all levels flipped -> unsat=1.
- Conflict at depth 0 (first prop conflicts, then flip conflicts) -> unsat=1 within 3 cycles of the last prop_done. Also: assert reset during BT_UNDO -> undo_req=0 next edge, IDLE.

Source files
------------

// File: rtl/dpll_control_if.sv
// dpll_control_if
//   Bundles every non-clock signal of the DPLL search sequencer: host
//   control/status, the decider read/write port, the BCP handshake and the
//   assignment-table undo handshake.
//
//   master : the sequencer (dpll_control)
//   slave  : its environment (host, decider, BCP unit, assignment table)
//
//   Host      : start -> ; <- busy, sat, unsat, error
//   Decider   : dec_read, dec_write, dec_back_idx -> ; <- dec_idx_in, dec_var_in, dec_val_in
//   Table     : <- var_assigned, all_assigned ; undo_req, undo_level -> ; <- undo_ack
//   BCP       : prop_start, prop_var, prop_val, prop_level -> ; <- prop_done, prop_conflict
interface dpll_control_if #(
    parameter int VAR_BITS = 9
);
    logic                start;
    logic                busy;
    logic                sat;
    logic                unsat;
    logic                error;

    logic                dec_read;
    logic                dec_write;
    logic [VAR_BITS-1:0] dec_back_idx;
    logic [VAR_BITS-1:0] dec_idx_in;
    logic [VAR_BITS-1:0] dec_var_in;
    logic                dec_val_in;

    logic                var_assigned;
    logic                all_assigned;

    logic                prop_start;
    logic [VAR_BITS-1:0] prop_var;
    logic                prop_val;
    logic [VAR_BITS-1:0] prop_level;
    logic                prop_done;
    logic                prop_conflict;

    logic                undo_req;
    logic [VAR_BITS-1:0] undo_level;
    logic                undo_ack;

    modport master (
        input  start,
        output busy, sat, unsat, error,
        output dec_read, dec_write, dec_back_idx,
        input  dec_idx_in, dec_var_in, dec_val_in,
        input  var_assigned, all_assigned,
        output prop_start, prop_var, prop_val, prop_level,
        input  prop_done, prop_conflict,
        output undo_req, undo_level,
        input  undo_ack
    );

    modport slave (
        output start,
        input  busy, sat, unsat, error,
        input  dec_read, dec_write, dec_back_idx,
        output dec_idx_in, dec_var_in, dec_val_in,
        output var_assigned, all_assigned,
        input  prop_start, prop_var, prop_val, prop_level,
        output prop_done, prop_conflict,
        input  undo_req, undo_level,
        output undo_ack
    );
endinterface

// File: rtl/dpll_control.sv
// dpll_control
//   Top-level DPLL search sequencer. Pulls branching literals from the
//   decider, hands each decision to the BCP unit, keeps the decision stack
//   and performs chronological backtracking (undo, flip, rewind decider) on
//   conflicts. Reports SAT / UNSAT / error.
//
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : dpll_control_if.master (host, decider, BCP, assignment table)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for start after reset
//   REWIND     | load decider pointer with 0
//   FETCH      | one-cycle decider read
//   CHECK      | decider entry valid; push decision or skip assigned var
//   PROP_WAIT  | waiting for BCP completion
//   BT_POP     | discard already-flipped levels from the top of the stack
//   BT_UNDO    | undo request held until the table acknowledges
//   BT_FLIP    | rewind decider past the flipped entry and propagate it
//   DONE_SAT   | satisfying assignment found
//   DONE_UNSAT | search space exhausted
//   ERR        | decider exhausted but table reports unassigned variables
module dpll_control #(
    parameter int NUM_VARS = 512,
    parameter int VAR_BITS = 9
) (
    input  logic           clock,
    input  logic           reset,
    dpll_control_if.master bus
);

    localparam logic [VAR_BITS-1:0] LAST_IDX = VAR_BITS'(NUM_VARS - 1);

    typedef enum logic [3:0] {
        IDLE,
        REWIND,
        FETCH,
        CHECK,
        PROP_WAIT,
        BT_POP,
        BT_UNDO,
        BT_FLIP,
        DONE_SAT,
        DONE_UNSAT,
        ERR
    } state_t;

    state_t              state;
    state_t              next_state;

    // depth spans 0..NUM_VARS, one bit wider than an index
    logic [VAR_BITS:0]   depth;
    logic [VAR_BITS:0]   depth_d;

    // decision stack; entries at or above depth are never read
    logic [VAR_BITS-1:0] stk_idx  [NUM_VARS];
    logic [VAR_BITS-1:0] stk_var  [NUM_VARS];
    logic                stk_val  [NUM_VARS];
    logic                stk_flip [NUM_VARS];

    logic [VAR_BITS-1:0] push_ptr;
    logic [VAR_BITS-1:0] top_ptr;
    logic [VAR_BITS-1:0] top_idx;
    logic [VAR_BITS-1:0] top_var;
    logic                top_val;
    logic                top_flip;

    logic                push_en;
    logic                flip_en;

    logic                dec_read_d;
    logic                dec_write_d;
    logic [VAR_BITS-1:0] dec_back_idx_d;
    logic                prop_start_d;
    logic [VAR_BITS-1:0] prop_var_d;
    logic                prop_val_d;
    logic [VAR_BITS-1:0] prop_level_d;
    logic                undo_req_d;
    logic [VAR_BITS-1:0] undo_level_d;
    logic                busy_d;
    logic                sat_d;
    logic                unsat_d;
    logic                error_d;

    // When depth == NUM_VARS the truncated pointer wraps to 0, and top_ptr
    // still lands on NUM_VARS-1 (NUM_VARS is a power of two).
    assign push_ptr = VAR_BITS'(depth);
    assign top_ptr  = VAR_BITS'(depth - 1'b1);
    assign top_idx  = stk_idx[top_ptr];
    assign top_var  = stk_var[top_ptr];
    assign top_val  = stk_val[top_ptr];
    assign top_flip = stk_flip[top_ptr];

    assign push_en  = (state == CHECK) && !bus.var_assigned;
    assign flip_en  = (state == BT_UNDO) && bus.undo_ack;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            depth            <= '0;
            bus.dec_read     <= 1'b0;
            bus.dec_write    <= 1'b0;
            bus.dec_back_idx <= '0;
            bus.prop_start   <= 1'b0;
            bus.prop_var     <= '0;
            bus.prop_val     <= 1'b0;
            bus.prop_level   <= '0;
            bus.undo_req     <= 1'b0;
            bus.undo_level   <= '0;
            bus.busy         <= 1'b0;
            bus.sat          <= 1'b0;
            bus.unsat        <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            state            <= next_state;
            depth            <= depth_d;
            bus.dec_read     <= dec_read_d;
            bus.dec_write    <= dec_write_d;
            bus.dec_back_idx <= dec_back_idx_d;
            bus.prop_start   <= prop_start_d;
            bus.prop_var     <= prop_var_d;
            bus.prop_val     <= prop_val_d;
            bus.prop_level   <= prop_level_d;
            bus.undo_req     <= undo_req_d;
            bus.undo_level   <= undo_level_d;
            bus.busy         <= busy_d;
            bus.sat          <= sat_d;
            bus.unsat        <= unsat_d;
            bus.error        <= error_d;
        end
    end

    // Stack storage needs no reset: nothing below depth is ever consumed.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stk_idx[push_ptr]  <= bus.dec_idx_in;
            stk_var[push_ptr]  <= bus.dec_var_in;
            stk_val[push_ptr]  <= bus.dec_val_in;
            stk_flip[push_ptr] <= 1'b0;
        end else if (flip_en) begin
            stk_val[top_ptr]   <= ~top_val;
            stk_flip[top_ptr]  <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        depth_d    = depth;
        case (state)
            IDLE, DONE_SAT, DONE_UNSAT, ERR: begin
                if (bus.start) begin
                    next_state = REWIND;
                    depth_d    = '0;
                end
            end
            REWIND: next_state = FETCH;
            FETCH:  next_state = CHECK;
            CHECK: begin
                if (!bus.var_assigned) begin
                    next_state = PROP_WAIT;
                    depth_d    = depth + 1'b1;
                end else if (bus.dec_idx_in != LAST_IDX) begin
                    next_state = FETCH;
                end else if (bus.all_assigned) begin
                    next_state = DONE_SAT;
                end else begin
                    next_state = ERR;
                end
            end
            PROP_WAIT: begin
                if (bus.prop_done) begin
                    // a conflict outranks a complete assignment
                    if (bus.prop_conflict)     next_state = BT_POP;
                    else if (bus.all_assigned) next_state = DONE_SAT;
                    else                       next_state = FETCH;
                end
            end
            BT_POP: begin
                if (depth == '0) begin
                    next_state = DONE_UNSAT;
                end else if (top_flip) begin
                    depth_d    = depth - 1'b1;
                end else begin
                    next_state = BT_UNDO;
                end
            end
            BT_UNDO: if (bus.undo_ack) next_state = BT_FLIP;
            BT_FLIP: next_state = PROP_WAIT;
            default: next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Computed one cycle ahead from next_state and registered, so no input
    // reaches a strobe output combinationally.
    always_comb begin
        dec_read_d     = (next_state == FETCH);
        dec_write_d    = (next_state == REWIND) || (next_state == BT_FLIP);
        dec_back_idx_d = '0;
        prop_start_d   = push_en || (next_state == BT_FLIP);
        prop_var_d     = bus.prop_var;
        prop_val_d     = bus.prop_val;
        prop_level_d   = bus.prop_level;
        undo_req_d     = (next_state == BT_UNDO);
        undo_level_d   = bus.undo_level;
        busy_d         = !((next_state == IDLE) || (next_state == DONE_SAT) ||
                           (next_state == DONE_UNSAT) || (next_state == ERR));
        sat_d          = (next_state == DONE_SAT);
        unsat_d        = (next_state == DONE_UNSAT);
        error_d        = (next_state == ERR);

        if (push_en) begin
            prop_var_d   = bus.dec_var_in;
            prop_val_d   = bus.dec_val_in;
            prop_level_d = VAR_BITS'(depth + 1'b1);
        end else if (next_state == BT_FLIP) begin
            // stack still holds the pre-flip value this cycle
            dec_back_idx_d = top_idx + 1'b1;
            prop_var_d     = top_var;
            prop_val_d     = ~top_val;
            prop_level_d   = VAR_BITS'(depth);
        end

        if (next_state == BT_UNDO) begin
            undo_level_d = VAR_BITS'(depth);
        end
    end

endmodule

// File: tb/tb_dpll_control.sv
// tb_dpll_control
//   Self-checking bench for dpll_control with NUM_VARS=16. Behavioural
//   decider, assignment table, BCP unit and undo responder surround the DUT.
//   Expected prop/undo events are queued when a scenario is set up and
//   popped as the DUT emits them.
module tb_dpll_control;

    localparam int NV = 16;
    localparam int VB = 4;

    typedef struct packed {
        logic [1:0]    kind;   // 0 decision prop, 1 undo, 2 flip prop
        logic [VB-1:0] v;
        logic          val;
        logic [VB-1:0] lvl;
        logic [VB-1:0] back;
    } ev_t;

    logic clock;
    logic reset;

    dpll_control_if #(.VAR_BITS(VB)) ifc();

    dpll_control #(.NUM_VARS(NV), .VAR_BITS(VB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // environment configuration (written only by the main initial block)
    logic [VB-1:0] dec_var_tbl [NV];
    logic          dec_val_tbl [NV];
    logic [NV-1:0] conf_tbl;
    logic [NV-1:0] prob_mask;
    logic [NV-1:0] pre_mask;
    logic          ack_en;

    // environment state
    logic [VB-1:0] d_ptr;
    logic [NV-1:0] assigned;
    logic [VB-1:0] lvl [NV];
    logic [1:0]    p_cnt;
    logic          p_conf;
    logic [VB-1:0] p_num;
    logic [1:0]    u_cnt;

    assign ifc.var_assigned = assigned[ifc.dec_var_in] | pre_mask[ifc.dec_var_in];
    assign ifc.all_assigned = &(assigned | pre_mask | ~prob_mask);

    // decider
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            d_ptr          <= '0;
            ifc.dec_idx_in <= '0;
            ifc.dec_var_in <= '0;
            ifc.dec_val_in <= 1'b0;
        end else if (ifc.dec_write) begin
            d_ptr <= ifc.dec_back_idx;
        end else if (ifc.dec_read) begin
            ifc.dec_idx_in <= d_ptr;
            ifc.dec_var_in <= dec_var_tbl[d_ptr];
            ifc.dec_val_in <= dec_val_tbl[d_ptr];
            d_ptr          <= d_ptr + 4'd1;
        end
    end

    // assignment table + BCP + undo responder
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            assigned          <= '0;
            p_cnt             <= 2'd0;
            p_conf            <= 1'b0;
            p_num             <= '0;
            u_cnt             <= 2'd0;
            ifc.prop_done     <= 1'b0;
            ifc.prop_conflict <= 1'b0;
            ifc.undo_ack      <= 1'b0;
        end else begin
            ifc.prop_done     <= 1'b0;
            ifc.prop_conflict <= 1'b0;
            ifc.undo_ack      <= 1'b0;
            if (ifc.prop_start) begin
                assigned[ifc.prop_var] <= 1'b1;
                lvl[ifc.prop_var]      <= ifc.prop_level;
                p_cnt                  <= 2'd2;
                p_conf                 <= conf_tbl[p_num];
                p_num                  <= p_num + 4'd1;
            end else if (p_cnt != 2'd0) begin
                p_cnt <= p_cnt - 2'd1;
                if (p_cnt == 2'd1) begin
                    ifc.prop_done     <= 1'b1;
                    ifc.prop_conflict <= p_conf;
                end
            end
            if (!ifc.undo_ack) begin
                if (u_cnt != 2'd0) begin
                    u_cnt <= u_cnt - 2'd1;
                    if (u_cnt == 2'd1) begin
                        ifc.undo_ack <= 1'b1;
                        for (int i = 0; i < NV; i++)
                            if (assigned[i] && lvl[i] >= ifc.undo_level) assigned[i] <= 1'b0;
                    end
                end else if (ifc.undo_req && ack_en) begin
                    u_cnt <= 2'd3;
                end
            end
        end
    end

    // ---------------------------------------------------------------- checking
    int  n_chk;
    int  n_pass;
    int  cyc;
    int  done_cyc;
    int  rd_cnt;
    logic undo_prev;
    ev_t sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic push_ev(input logic [1:0] k, input logic [VB-1:0] v, input logic val,
                           input logic [VB-1:0] l, input logic [VB-1:0] b);
        ev_t e;
        e = {k, v, val, l, b};
        sb.push_back(e);
    endtask

    task automatic sb_compare(input string tag, input ev_t act);
        ev_t e;
        check("sb_avail", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(tag, 32'(act), 32'(e));
        end
    endtask

    task automatic step();
        ev_t        act;
        logic [3:0] strobes;
        @(negedge clock);
        cyc++;
        if (ifc.dec_read)  rd_cnt++;
        if (ifc.prop_done) done_cyc = cyc;
        strobes = {ifc.dec_read, ifc.dec_write, ifc.prop_start, ifc.undo_req};
        if (strobes != 4'b0)
            check("strobe_mutex", 32'($onehot(strobes) || strobes == 4'b0110), 32'd1);
        if (ifc.prop_start) begin
            act = {(ifc.dec_write ? 2'd2 : 2'd0), ifc.prop_var, ifc.prop_val, ifc.prop_level,
                   (ifc.dec_write ? ifc.dec_back_idx : 4'd0)};
            sb_compare("prop_evt", act);
        end
        if (ifc.undo_req && !undo_prev) begin
            act = {2'd1, 4'd0, 1'b0, ifc.undo_level, 4'd0};
            sb_compare("undo_evt", act);
        end
        undo_prev = ifc.undo_req;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ifc.start = 1'b0;
        ack_en    = 1'b1;
        conf_tbl  = '0;
        prob_mask = '0;
        pre_mask  = '0;
        for (int i = 0; i < NV; i++) begin
            dec_var_tbl[i] = 4'(i % 4);
            dec_val_tbl[i] = i[0];
        end
        sb.delete();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic start_pulse();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic [3:0] exp_flags);
        int n;
        n = 0;
        while (!(ifc.sat || ifc.unsat || ifc.error) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'({ifc.sat, ifc.unsat, ifc.error, ifc.busy}), 32'(exp_flags));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        cyc       = 0;
        done_cyc  = 0;
        rd_cnt    = 0;
        undo_prev = 1'b0;
        reset     = 1'b0;
        ifc.start = 1'b0;
        #2;

        // reset state
        do_reset();
        check("rst_outs", 32'({ifc.dec_read, ifc.dec_write, ifc.dec_back_idx, ifc.prop_start,
                               ifc.prop_var, ifc.prop_val, ifc.prop_level, ifc.undo_req,
                               ifc.undo_level, ifc.busy, ifc.sat, ifc.unsat, ifc.error}), 32'd0);
        check("rst_depth", 32'(dut.depth), 32'd0);

        // four conflict-free decisions, start while busy ignored
        prob_mask = 16'h000F;
        push_ev(2'd0, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd0, 4'd1, 1'b1, 4'd2, 4'd0);
        push_ev(2'd0, 4'd2, 1'b0, 4'd3, 4'd0);
        push_ev(2'd0, 4'd3, 1'b1, 4'd4, 4'd0);
        start_pulse();
        check("busy_rise", 32'(ifc.busy), 32'd1);
        step();
        step();
        step();
        start_pulse();
        wait_done("sat4_flags", 200, 4'b1000);
        check("sat4_depth", 32'(dut.depth), 32'd4);

        // restart after DONE_SAT: rewind to 0, every entry already assigned
        rd_cnt = 0;
        start_pulse();
        check("restart_rewind", 32'({ifc.dec_write, ifc.dec_back_idx, ifc.sat, ifc.busy}),
              32'({1'b1, 4'd0, 1'b0, 1'b1}));
        wait_done("restart_flags", 200, 4'b1000);
        check("restart_reads", 32'(rd_cnt), 32'd16);
        check("restart_depth", 32'(dut.depth), 32'd0);

        // skip assigned entries 1 and 2
        do_reset();
        prob_mask = 16'h000F;
        pre_mask  = 16'h0006;
        push_ev(2'd0, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd0, 4'd3, 1'b1, 4'd2, 4'd0);
        rd_cnt = 0;
        start_pulse();
        wait_done("skip_flags", 200, 4'b1000);
        check("skip_reads", 32'(rd_cnt), 32'd4);
        check("skip_depth", 32'(dut.depth), 32'd2);

        // single conflict at level 2 on var 5 from decider entry 7
        do_reset();
        prob_mask = 16'h00FF;
        pre_mask  = 16'h00DE;
        dec_var_tbl[0] = 4'd0; dec_val_tbl[0] = 1'b0;
        dec_var_tbl[1] = 4'd1; dec_var_tbl[2] = 4'd2; dec_var_tbl[3] = 4'd3;
        dec_var_tbl[4] = 4'd4; dec_var_tbl[5] = 4'd6; dec_var_tbl[6] = 4'd7;
        dec_var_tbl[7] = 4'd5; dec_val_tbl[7] = 1'b1;
        conf_tbl = 16'b010;
        push_ev(2'd0, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd0, 4'd5, 1'b1, 4'd2, 4'd0);
        push_ev(2'd1, 4'd0, 1'b0, 4'd2, 4'd0);
        push_ev(2'd2, 4'd5, 1'b0, 4'd2, 4'd8);
        start_pulse();
        wait_done("flip_flags", 300, 4'b1000);
        check("flip_depth", 32'(dut.depth), 32'd2);

        // flipped level conflicts again, pop to level 1, finally unsat
        do_reset();
        prob_mask = 16'h000F;
        conf_tbl  = 16'b110110;
        push_ev(2'd0, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd0, 4'd1, 1'b1, 4'd2, 4'd0);
        push_ev(2'd1, 4'd0, 1'b0, 4'd2, 4'd0);
        push_ev(2'd2, 4'd1, 1'b0, 4'd2, 4'd2);
        push_ev(2'd1, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd2, 4'd0, 1'b1, 4'd1, 4'd1);
        push_ev(2'd0, 4'd1, 1'b1, 4'd2, 4'd0);
        push_ev(2'd1, 4'd0, 1'b0, 4'd2, 4'd0);
        push_ev(2'd2, 4'd1, 1'b0, 4'd2, 4'd2);
        start_pulse();
        wait_done("pop_flags", 400, 4'b0100);
        check("pop_depth", 32'(dut.depth), 32'd0);

        // conflict down to depth 0, unsat latency
        do_reset();
        prob_mask = 16'h0001;
        conf_tbl  = 16'b11;
        push_ev(2'd0, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd1, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd2, 4'd0, 1'b1, 4'd1, 4'd1);
        start_pulse();
        wait_done("d0_flags", 200, 4'b0100);
        check("unsat_lat", 32'(cyc - done_cyc), 32'd3);

        // reset asserted while the undo request is held
        do_reset();
        prob_mask = 16'h0001;
        conf_tbl  = 16'b1;
        ack_en    = 1'b0;
        push_ev(2'd0, 4'd0, 1'b0, 4'd1, 4'd0);
        push_ev(2'd1, 4'd0, 1'b0, 4'd1, 4'd0);
        start_pulse();
        for (int n = 0; n < 50 && !ifc.undo_req; n++) step();
        check("undo_held", 32'(ifc.undo_req), 32'd1);
        reset = 1'b1;
        step();
        check("rst_mid_outs", 32'({ifc.undo_req, ifc.busy, ifc.sat, ifc.unsat, ifc.error,
                                   ifc.prop_start, ifc.dec_read, ifc.dec_write}), 32'd0);
        check("rst_mid_state", 32'(dut.state), 32'd0);
        check("rst_mid_depth", 32'(dut.depth), 32'd0);
        check("rst_mid_sb", 32'(sb.size()), 32'd0);
        reset  = 1'b0;
        ack_en = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
